id_ex_alu_issue: RTL and testbench

ID/EX stage block that drives the execute-stage ALU. It decodes RISC-V aluop/funct3/funct7 into the 4-bit alu_control code the ALU consumes. It selects forwarded operands and the immediate, then registers everything into the ID/EX pipeline register, with stall, flush and valid tracking. It is the producer end of the alu a/b/alu_control interface.

---
 rtl/id_ex_alu_issue.sv | 215 +++++++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_issue.sv
// -----------------------------------------------------------------------------
// id_ex_alu_issue
//
// ID/EX pipeline stage that issues work to the execute-stage ALU.
//   * Decodes aluop/funct3/funct7_5 into the 4-bit alu_control code.
//   * Selects forwarded operands (A, B) and the immediate for B.
//   * Registers everything into the ID/EX register with stall, flush and
//     valid tracking. The latency is exactly one cycle.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   decode-side handshake (in_ready = !stall)
//   stall, flush          hazard-unit hold and branch squash
//   aluop, funct3,
//   funct7_5, alu_src     decode controls
//   rs1_data, rs2_data,
//   imm                   register-file operands and the immediate
//   fwd_a_sel, fwd_b_sel  forwarding selects (00 reg, 01 EX/MEM, 10 MEM/WB,
//                         11 reg)
//   ex_mem_result,
//   mem_wb_result         forwarded results
//   rd_in                 destination register
//   alu_a, alu_b,
//   alu_control           registered ALU interface
//   store_data            registered forwarded rs2 (before the imm mux)
//   rd_out, out_valid     registered destination and valid
//
// Build option
//   ILLEGAL_ALU_DETECT_EN adds the registered output illegal_op, which flags
//   R-type encodings with funct7_5 set on an opcode that does not use it, and
//   SLLI with funct7_5 set. The instruction still issues with its table decode.
// -----------------------------------------------------------------------------
module id_ex_alu_issue #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            aluop,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  alu_src,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [1:0]            fwd_a_sel,
  input  logic [1:0]            fwd_b_sel,
  input  logic [XLEN-1:0]       ex_mem_result,
  input  logic [XLEN-1:0]       mem_wb_result,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            alu_control,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  out_valid
`ifdef ILLEGAL_ALU_DETECT_EN
  ,
  output logic                  illegal_op
`endif
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [1:0] AOP_MEM    = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ITYPE  = 2'b11;

  // Forwarding select; 11 is unused and falls back to the register value.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] ex_mem_val,
    input logic [XLEN-1:0] mem_wb_val
  );
    case (sel)
      2'b01:   return ex_mem_val;
      2'b10:   return mem_wb_val;
      default: return reg_val;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  alu_op_e alu_control_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned and infer a latch.
    alu_control_d = ALU_ADD;
    case (aluop)
      AOP_MEM:    alu_control_d = ALU_ADD;
      AOP_BRANCH: alu_control_d = ALU_SUB;
      default: begin
        case (funct3)
          // For I-type, bit 30 is immediate data, so ADDI never becomes SUB.
          3'b000: alu_control_d = (aluop == AOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control_d = ALU_SLL;
          3'b010: alu_control_d = ALU_SLT;
          3'b011: alu_control_d = ALU_SLTU;
          3'b100: alu_control_d = ALU_XOR;
          // Shift-right immediates do encode SRA/SRL in bit 30.
          3'b101: alu_control_d = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control_d = ALU_OR;
          default: alu_control_d = ALU_AND;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fwd_a_val;
  logic [XLEN-1:0] fwd_b_val;

  assign fwd_a_val = fwd_mux(fwd_a_sel, rs1_data, ex_mem_result, mem_wb_result);
  assign fwd_b_val = fwd_mux(fwd_b_sel, rs2_data, ex_mem_result, mem_wb_result);

  logic [XLEN-1:0] alu_a_d;
  logic [XLEN-1:0] alu_b_d;
  logic [XLEN-1:0] store_data_d;

  assign alu_a_d      = fwd_a_val;
  assign alu_b_d      = alu_src ? imm : fwd_b_val;
  assign store_data_d = fwd_b_val;

`ifdef ILLEGAL_ALU_DETECT_EN
  logic illegal_d;

  // Only a valid instruction can raise the flag; a bubble load clears it.
  assign illegal_d = in_valid &&
                     (((aluop == AOP_RTYPE) && funct7_5 &&
                       (funct3 != 3'b000) && (funct3 != 3'b101)) ||
                      ((aluop == AOP_ITYPE) && funct7_5 && (funct3 == 3'b001)));
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register: reset > flush > stall > load (bubble if !in_valid)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]       alu_a_q;
  logic [XLEN-1:0]       alu_b_q;
  logic [3:0]            alu_control_q;
  logic [XLEN-1:0]       store_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  valid_q;
`ifdef ILLEGAL_ALU_DETECT_EN
  logic                  illegal_q;
`endif

  logic clear_stage;
  logic load_stage;

  // A bubble (reset, flush, or an invalid load) zeroes the whole stage.
  assign clear_stage = !rst_n || flush || (!stall && !in_valid);
  assign load_stage  = !stall;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (clear_stage) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= ALU_ADD;
      store_data_q  <= '0;
      rd_q          <= '0;
      valid_q       <= 1'b0;
`ifdef ILLEGAL_ALU_DETECT_EN
      illegal_q     <= 1'b0;
`endif
    end else if (load_stage) begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      store_data_q  <= store_data_d;
      rd_q          <= rd_in;
      valid_q       <= 1'b1;
`ifdef ILLEGAL_ALU_DETECT_EN
      illegal_q     <= illegal_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = !stall;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign store_data  = store_data_q;
  assign rd_out      = rd_q;
  assign out_valid   = valid_q;
`ifdef ILLEGAL_ALU_DETECT_EN
  assign illegal_op  = illegal_q;
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_id_ex_alu_issue
//
// Directed self-checking bench for id_ex_alu_issue. Each scenario task drives
// inputs just after a rising edge, advances one edge, and compares the
// registered outputs against hand-computed values. The illegal-op scenario
// is built only when ILLEGAL_ALU_DETECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_ex_alu_issue;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OBS_W      = 1 + 4 + 3 * XLEN + REG_ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic [1:0]            aluop;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  alu_src;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN-1:0]       imm;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [XLEN-1:0]       ex_mem_result;
  logic [XLEN-1:0]       mem_wb_result;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [3:0]            alu_control;
  logic [XLEN-1:0]       store_data;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  out_valid;
`ifdef ILLEGAL_ALU_DETECT_EN
  logic                  illegal_op;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .stall         (stall),
    .flush         (flush),
    .aluop         (aluop),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_src       (alu_src),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm           (imm),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .ex_mem_result (ex_mem_result),
    .mem_wb_result (mem_wb_result),
    .rd_in         (rd_in),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_control   (alu_control),
    .store_data    (store_data),
    .rd_out        (rd_out),
    .out_valid     (out_valid)
`ifdef ILLEGAL_ALU_DETECT_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  // All registered outputs in one vector: valid, ctl, a, b, store, rd.
  logic [OBS_W-1:0] obs;
  assign obs = {out_valid, alu_control, alu_a, alu_b, store_data, rd_out};

  function automatic logic [OBS_W-1:0] expv(
    input logic                  v,
    input logic [3:0]            ctl,
    input logic [XLEN-1:0]       a,
    input logic [XLEN-1:0]       b,
    input logic [XLEN-1:0]       sd,
    input logic [REG_ADDR_W-1:0] rd
  );
    return {v, ctl, a, b, sd, rd};
  endfunction

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic src);
    aluop    = op;
    funct3   = f3;
    funct7_5 = f7;
    alu_src  = src;
  endtask

  task automatic set_base();
    in_valid      = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    rs1_data      = 32'd20;
    rs2_data      = 32'd5;
    imm           = 32'h0000_0000;
    fwd_a_sel     = 2'b00;
    fwd_b_sel     = 2'b00;
    ex_mem_result = 32'd100;
    mem_wb_result = 32'd7;
    rd_in         = 5'd3;
    set_op(2'b10, 3'b000, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [OBS_W-1:0] e;
    set_base();
    rst_n = 1'b0;
    tick();
    stall = 1'b1;  // reset must override stall
    flush = 1'b0;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else pass_cnt++;
`ifdef ILLEGAL_ALU_DETECT_EN
    total_cnt++;
    if (illegal_op !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal_op);
    else pass_cnt++;
`endif
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    e = expv(1'b1, 4'b0000, 32'd20, 32'd5, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL reset_release_add: got %h expected %h", obs, e);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rtype();
    logic [2:0] f3_t  [10] = '{3'b000, 3'b111, 3'b110, 3'b101, 3'b011,
                               3'b101, 3'b001, 3'b010, 3'b100, 3'b000};
    logic       f7_t  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] ctl_t [10] = '{4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001,
                               4'b0110, 4'b0101, 4'b1000, 4'b0100, 4'b0000};
    logic [OBS_W-1:0] e;
    set_base();
    // Back-to-back issue: every edge loads a new instruction.
    for (int i = 0; i < 10; i++) begin
      set_op(2'b10, f3_t[i], f7_t[i], 1'b0);
      rd_in = 5'(i + 1);
      tick();
      e = expv(1'b1, ctl_t[i], 32'd20, 32'd5, 32'd5, 5'(i + 1));
      total_cnt++;
      if (obs !== e) $display("FAIL rtype_%0d: got %h expected %h", i, obs, e);
      else pass_cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_itype();
    logic [OBS_W-1:0] e;
    set_base();
    imm = 32'hFFFF_FFFC;
    set_op(2'b11, 3'b000, 1'b1, 1'b1);  // ADDI with bit 30 set
    tick();
    e = expv(1'b1, 4'b0000, 32'd20, 32'hFFFF_FFFC, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL itype_addi: got %h expected %h", obs, e);
    else pass_cnt++;

    set_op(2'b11, 3'b101, 1'b1, 1'b1);  // SRAI
    tick();
    e = expv(1'b1, 4'b0111, 32'd20, 32'hFFFF_FFFC, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL itype_srai: got %h expected %h", obs, e);
    else pass_cnt++;

    set_op(2'b00, 3'b111, 1'b1, 1'b1);  // load/store address add
    tick();
    e = expv(1'b1, 4'b0000, 32'd20, 32'hFFFF_FFFC, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL aluop_mem: got %h expected %h", obs, e);
    else pass_cnt++;

    set_op(2'b01, 3'b000, 1'b0, 1'b0);  // branch compare
    tick();
    e = expv(1'b1, 4'b0001, 32'd20, 32'd5, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL aluop_branch: got %h expected %h", obs, e);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_forwarding();
    logic [OBS_W-1:0] e;
    set_base();
    fwd_a_sel = 2'b01;
    fwd_b_sel = 2'b10;
    tick();
    e = expv(1'b1, 4'b0000, 32'd100, 32'd7, 32'd7, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL fwd_ex_mem_wb: got %h expected %h", obs, e);
    else pass_cnt++;

    fwd_a_sel = 2'b10;
    fwd_b_sel = 2'b01;
    tick();
    e = expv(1'b1, 4'b0000, 32'd7, 32'd100, 32'd100, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL fwd_swap: got %h expected %h", obs, e);
    else pass_cnt++;

    fwd_a_sel = 2'b11;
    fwd_b_sel = 2'b11;
    tick();
    e = expv(1'b1, 4'b0000, 32'd20, 32'd5, 32'd5, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL fwd_sel_11: got %h expected %h", obs, e);
    else pass_cnt++;

    // store_data keeps the forwarded rs2 even when B takes the immediate
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b01;
    imm       = 32'h0000_0040;
    set_op(2'b00, 3'b010, 1'b0, 1'b1);
    tick();
    e = expv(1'b1, 4'b0000, 32'd20, 32'h0000_0040, 32'd100, 5'd3);
    total_cnt++;
    if (obs !== e) $display("FAIL fwd_store_data: got %h expected %h", obs, e);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_flush();
    logic [OBS_W-1:0] e;
    logic [OBS_W-1:0] held;
    set_base();
    rd_in = 5'd4;
    tick();
    held = expv(1'b1, 4'b0000, 32'd20, 32'd5, 32'd5, 5'd4);
    total_cnt++;
    if (obs !== held) $display("FAIL stall_preload: got %h expected %h", obs, held);
    else pass_cnt++;

    for (int i = 0; i < 3; i++) begin
      stall    = 1'b1;
      rs1_data = 32'(99 + i);
      rs2_data = 32'(55 + i);
      rd_in    = 5'(10 + i);
      in_valid = i[0];
      set_op(2'b10, 3'b100, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== held) $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, held);
      else pass_cnt++;
    end

    // First non-stalled edge loads the inputs present at that edge.
    stall    = 1'b0;
    in_valid = 1'b1;
    rs1_data = 32'd33;
    rs2_data = 32'd11;
    rd_in    = 5'd9;
    set_op(2'b10, 3'b000, 1'b1, 1'b0);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL unstall_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    tick();
    e = expv(1'b1, 4'b0001, 32'd33, 32'd11, 32'd11, 5'd9);
    total_cnt++;
    if (obs !== e) $display("FAIL unstall_load: got %h expected %h", obs, e);
    else pass_cnt++;

    // Flush wins over stall.
    stall = 1'b1;
    flush = 1'b1;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL flush_over_stall: got %h expected 0", obs);
    else pass_cnt++;

    // Load valid, then an invalid load becomes a bubble.
    stall = 1'b0;
    flush = 1'b0;
    set_op(2'b10, 3'b110, 1'b0, 1'b0);
    tick();
    e = expv(1'b1, 4'b0011, 32'd33, 32'd11, 32'd11, 5'd9);
    total_cnt++;
    if (obs !== e) $display("FAIL reload_or: got %h expected %h", obs, e);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL invalid_bubble: got %h expected 0", obs);
    else pass_cnt++;

    // Reset asserted mid-stall clears; the first edge after release loads.
    in_valid = 1'b1;
    tick();
    stall = 1'b1;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_mid_stall: got %h expected 0", obs);
    else pass_cnt++;
    rst_n = 1'b1;
    stall = 1'b0;
    set_op(2'b10, 3'b111, 1'b0, 1'b0);
    tick();
    e = expv(1'b1, 4'b0010, 32'd33, 32'd11, 32'd11, 5'd9);
    total_cnt++;
    if (obs !== e) $display("FAIL reset_release_load: got %h expected %h", obs, e);
    else pass_cnt++;
  endtask

`ifdef ILLEGAL_ALU_DETECT_EN
  // ---------------------------------------------------------------------------
  task automatic test_illegal();
    set_base();
    set_op(2'b10, 3'b111, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if ({illegal_op, alu_control} !== {1'b1, 4'b0010})
      $display("FAIL illegal_and_f7: got %b/%b expected 1/0010", illegal_op, alu_control);
    else pass_cnt++;

    set_op(2'b10, 3'b000, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if ({illegal_op, alu_control} !== {1'b0, 4'b0000})
      $display("FAIL illegal_clear_legal: got %b/%b expected 0/0000", illegal_op, alu_control);
    else pass_cnt++;

    set_op(2'b11, 3'b001, 1'b1, 1'b1);
    tick();
    total_cnt++;
    if ({illegal_op, alu_control} !== {1'b1, 4'b0101})
      $display("FAIL illegal_slli_f7: got %b/%b expected 1/0101", illegal_op, alu_control);
    else pass_cnt++;

    stall = 1'b1;
    set_op(2'b10, 3'b000, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if (illegal_op !== 1'b1) $display("FAIL illegal_hold_stall: got %b expected 1", illegal_op);
    else pass_cnt++;

    flush = 1'b1;
    tick();
    total_cnt++;
    if (illegal_op !== 1'b0) $display("FAIL illegal_flush: got %b expected 0", illegal_op);
    else pass_cnt++;

    // Encodings that use bit 30 legitimately stay legal.
    stall = 1'b0;
    flush = 1'b0;
    set_op(2'b11, 3'b000, 1'b1, 1'b1);
    tick();
    total_cnt++;
    if (illegal_op !== 1'b0) $display("FAIL illegal_addi_f7: got %b expected 0", illegal_op);
    else pass_cnt++;

    in_valid = 1'b0;
    set_op(2'b10, 3'b111, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if (illegal_op !== 1'b0) $display("FAIL illegal_bubble: got %b expected 0", illegal_op);
    else pass_cnt++;
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    set_base();
    #1;
    test_reset();
    test_rtype();
    test_itype();
    test_forwarding();
    test_stall_flush();
`ifdef ILLEGAL_ALU_DETECT_EN
    test_illegal();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
